fifo_uart_tx: RTL and testbench

Serial transmitter that drains a byte FIFO and sends each entry as an asynchronous UART frame on a single output line. It sits directly downstream of the `fifo` block:
- it reads the FIFO's head word and empty flag;
- it issues one read-enable pulse per frame.

Back-to-back frames go out with no idle gap while the FIFO holds data.

---
 rtl/uart_pkg.sv | 19 +
 rtl/baud_gen.sv | 28 ++
 rtl/fifo_uart_tx.sv | 109 ++++++++++
 tb/tb_fifo_uart_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the FIFO-fed UART transmitter
package uart_pkg;

  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Data narrower than MAX_DATA_BITS must arrive zero-extended so the XOR is unaffected.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// rtl/baud_gen.sv - bit-period counter with a tick on the last cycle of each bit
module baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a byte FIFO onto an asynchronous UART line, back to back
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic [DATA_BITS-1:0] fifo_data_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_re_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int IW = $clog2(DATA_BITS) + 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 stop_cnt_q;
  logic                 parity_q;
  logic                 tick;
  logic                 frame_end;
  logic                 pop;

  assign frame_end = (state_q == STOP) && tick && (stop_cnt_q == STOP_LAST);
  assign pop       = en_i && !fifo_empty_i && ((state_q == IDLE) || frame_end);
  assign fifo_re_o = pop;

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .clr_i (pop),
    .tick_o(tick)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (pop) state_d = START;
      START:  if (tick) state_d = DATA;
      DATA: begin
        if (tick && (bit_idx_q == LAST_BIT)) begin
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP:   if (frame_end) state_d = pop ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Parity is captured with the word so it does not depend on the shifted-out bits.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
    end else if (pop) begin
      shreg_q    <= fifo_data_i;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= calc_parity(MAX_DATA_BITS'(fifo_data_i), PARITY_ODD != 0);
    end else if (tick) begin
      if (state_q == DATA) begin
        shreg_q   <= shreg_q >> 1;
        bit_idx_q <= (bit_idx_q == LAST_BIT) ? '0 : bit_idx_q + IW'(1);
      end
      if (state_q == STOP) begin
        stop_cnt_q <= ~stop_cnt_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_o   <= 1'b1;
      busy_o <= 1'b0;
    end else begin
      busy_o <= (state_q != IDLE);
      unique case (state_q)
        START:   tx_o <= 1'b0;
        DATA:    tx_o <= shreg_q[0];
        PARITY:  tx_o <= parity_q;
        default: tx_o <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic en;

  // first-word-fall-through byte FIFO feeding the main transmitter
  logic [7:0] mem [16];
  logic [4:0] wr_ptr;
  logic [4:0] rd_ptr = '0;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_re, tx, busy;
  int         re_cnt = 0;
  int         bad_re = 0;

  assign fifo_data  = mem[rd_ptr[3:0]];
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_re) begin
      rd_ptr <= rd_ptr + 5'd1;
      re_cnt <= re_cnt + 1;
    end
    if (fifo_re && fifo_empty) bad_re <= bad_re + 1;
  end

  // single-entry sources for the odd- and even-parity transmitters
  int   po_wr, pe_wr;
  int   po_rd = 0;
  int   pe_rd = 0;
  logic po_empty, pe_empty, po_re, pe_re, po_tx, pe_tx, po_busy, pe_busy;
  assign po_empty = (po_wr == po_rd);
  assign pe_empty = (pe_wr == pe_rd);
  always @(posedge clk) begin
    if (po_re) po_rd <= po_rd + 1;
    if (pe_re) pe_rd <= pe_rd + 1;
  end

  fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty),
    .fifo_re_o(fifo_re), .tx_o(tx), .busy_o(busy));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_po (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .fifo_data_i(8'h07), .fifo_empty_i(po_empty),
    .fifo_re_o(po_re), .tx_o(po_tx), .busy_o(po_busy));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_pe (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .fifo_data_i(8'h07), .fifo_empty_i(pe_empty),
    .fifo_re_o(pe_re), .tx_o(pe_tx), .busy_o(pe_busy));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input int s);
    case (s)
      0:       return tx;
      1:       return po_tx;
      default: return pe_tx;
    endcase
  endfunction

  function automatic logic busy_of(input int s);
    case (s)
      0:       return busy;
      1:       return po_busy;
      default: return pe_busy;
    endcase
  endfunction

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  // Leaves the caller on the first negedge with the line low.
  task automatic wait_start(input int s, input string tag);
    int n = 0;
    while (tx_of(s) !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 3000), 32'd1);
  endtask

  // Samples each bit mid-period; returns bits LSB=start and the busy-high cycle count.
  task automatic sample_frame(input int s, input int nbits, output logic [11:0] v, output int blen);
    v = '0;
    blen = int'(busy_of(s));
    for (int i = 0; i < nbits; i++) begin
      repeat (2) begin @(negedge clk); blen += int'(busy_of(s)); end
      v[i] = tx_of(s);
      repeat (2) begin @(negedge clk); blen += int'(busy_of(s)); end
    end
  endtask

  initial begin
    logic [11:0] v;
    int          bl;
    int          re0;
    int          bad;

    rstn = 1'b0; en = 1'b0; wr_ptr = '0; po_wr = 0; pe_wr = 0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_re", 32'(fifo_re), 32'd0);
    rstn = 1'b1; en = 1'b1;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_re !== 1'b0) bad++;
    end
    check("idle_hold", 32'(bad), 32'd0);

    re0 = re_cnt;
    push(8'hA5);
    wait_start(0, "a5_start");
    sample_frame(0, 10, v, bl);
    check("a5_frame", 32'(v), 32'h34A);
    check("a5_len", 32'(bl), 32'd40);
    check("a5_busy_fall", 32'(busy), 32'd0);
    check("a5_tx_idle", 32'(tx), 32'd1);
    check("a5_pulses", 32'(re_cnt - re0), 32'd1);

    re0 = re_cnt;
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_start(0, "b2b_start");
    sample_frame(0, 10, v, bl);
    check("b2b_frame0", 32'(v), 32'h200);
    check("b2b_nogap0", 32'(tx), 32'd0);
    check("b2b_busy0", 32'(busy), 32'd1);
    sample_frame(0, 10, v, bl);
    check("b2b_frame1", 32'(v), 32'h3FE);
    check("b2b_nogap1", 32'(tx), 32'd0);
    sample_frame(0, 10, v, bl);
    check("b2b_frame2", 32'(v), 32'h278);
    check("b2b_busy_end", 32'(busy), 32'd0);
    check("b2b_pulses", 32'(re_cnt - re0), 32'd3);
    check("b2b_empty", 32'(fifo_empty), 32'd1);

    po_wr = 1;
    wait_start(1, "podd_start");
    sample_frame(1, 11, v, bl);
    check("podd_frame", 32'(v), 32'h40E);
    check("podd_len", 32'(bl), 32'd44);
    pe_wr = 1;
    wait_start(2, "peven_start");
    sample_frame(2, 11, v, bl);
    check("peven_frame", 32'(v), 32'h60E);

    push(8'h12); push(8'h34);
    wait_start(0, "en_start");
    en = 1'b0;
    sample_frame(0, 10, v, bl);
    check("en_frame", 32'(v), 32'h224);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("en_hold_high", 32'(bad), 32'd0);
    check("en_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
    en = 1'b1;
    wait_start(0, "en_resume");
    sample_frame(0, 10, v, bl);
    check("en_frame2", 32'(v), 32'h268);

    push(8'h55); push(8'h0F);
    wait_start(0, "rst_start");
    repeat (9) @(negedge clk);
    check("rst_mid_low", 32'(tx), 32'd0);
    #2;
    en = 1'b0; rstn = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx), 32'd1);
    check("rst_async_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
    rstn = 1'b1; en = 1'b1;
    wait_start(0, "rst_resume");
    sample_frame(0, 10, v, bl);
    check("rst_frame", 32'(v), 32'h21E);

    check("re_when_empty", 32'(bad_re), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
